// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the VLX bit-stream reader.
package or1200_vlx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPendFf,
        StMarker
    } vlx_state_e;

    localparam logic [1:0] VLX_SPR_STAT  = 2'b00;
    localparam logic [1:0] VLX_SPR_BUF   = 2'b01;
    localparam logic [1:0] VLX_SPR_ADDR  = 2'b10;
    localparam logic [1:0] VLX_SPR_STATS = 2'b11;

    localparam int unsigned BUF_W       = 32;
    localparam int unsigned FETCH_LIMIT = 24;

    function automatic logic [4:0] clamp_bits(input logic [4:0] n);
        return (n > 5'd16) ? 5'd16 : n;
    endfunction

endpackage

// File: rtl/or1200_vlx_unstuff.sv
// Byte fetch sequencing: strips FF 00 stuffing and detects JPEG markers.
module or1200_vlx_unstuff
    import or1200_vlx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       resume_i,
    input  logic       space_ok_i,
    input  logic       ack_i,
    input  logic [7:0] rd_dat_i,
    output logic       rd_req_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       stuff_drop_o,
    output logic       marker_o,
    output logic [7:0] marker_code_o
);

    vlx_state_e state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic       marker_q, marker_d;
    logic [7:0] code_q, code_d;
    logic       ack_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            pend_q   <= 8'h00;
            marker_q <= 1'b0;
            code_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            marker_q <= marker_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        marker_d     = marker_q;
        code_d       = code_q;
        byte_valid_o = 1'b0;
        byte_o       = rd_dat_i;
        stuff_drop_o = 1'b0;
        // space_ok_i already accounts for this cycle's consume
        rd_req_o     = ((state_q == StFetch) || (state_q == StPendFf)) && space_ok_i;
        ack_ok       = ack_i & rd_req_o;

        if (start_i) begin
            state_d  = StFetch;
            pend_d   = 8'h00;
            marker_d = 1'b0;
            code_d   = 8'h00;
        end else begin
            if (resume_i) begin
                marker_d = 1'b0;
                if (state_q == StMarker) begin
                    state_d = StFetch;
                end
            end
            unique case (state_q)
                StFetch: begin
                    if (ack_ok) begin
                        if (rd_dat_i == 8'hFF) begin
                            pend_d  = rd_dat_i;
                            state_d = StPendFf;
                        end else begin
                            byte_valid_o = 1'b1;
                        end
                    end
                end
                StPendFf: begin
                    if (ack_ok) begin
                        if (rd_dat_i == 8'h00) begin
                            byte_valid_o = 1'b1;
                            byte_o       = pend_q;
                            stuff_drop_o = 1'b1;
                            state_d      = StFetch;
                        end else begin
                            marker_d = 1'b1;
                            code_d   = rd_dat_i;
                            state_d  = StMarker;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign marker_o      = marker_q;
    assign marker_code_o = code_q;

endmodule

// File: rtl/or1200_vlx_reader.sv
// JPEG VLX bit-stream reader: byte fetch, bit buffer, get-bits service and SPRs.
// Optional stuffing statistics counter enabled by `define OR1200_VLX_READER_STATS_EN.
module or1200_vlx_reader #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic        PAD_BIT    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        get_bit_op_i,
    input  logic [4:0]  num_bits_i,
    output logic [31:0] bits_o,
    output logic        stall_cpu_o,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic [7:0]  rd_dat_i,
    input  logic        ack_i,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o
);
    import or1200_vlx_pkg::*;

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [5:0]       fill_q, fill_d;
    logic             underflow_q, underflow_d;
    logic [31:0]      bits_q, bits_d;
    logic [31:0]      addr_q, addr_d;

    logic [4:0]       n;
    logic [5:0]       n6;
    logic             start_wr, stat_wr, short, serve, pad_fill, space_ok;
    logic [5:0]       fill_c;
    logic [BUF_W-1:0] buf_c, src, taken;
    logic             byte_valid, stuff_drop, marker;
    logic [7:0]       byte_val, marker_code;
    logic [31:0]      stats_val;

    assign n        = clamp_bits(num_bits_i);
    assign n6       = {1'b0, n};
    assign start_wr = spr_cs & spr_write & (spr_addr == VLX_SPR_ADDR);
    assign stat_wr  = spr_cs & spr_write & (spr_addr == VLX_SPR_STAT);
    assign short    = fill_q < n6;

    // A start write flushes the buffer, so a coincident op must be retried.
    assign stall_cpu_o = get_bit_op_i & ((short & ~marker) | start_wr);
    assign serve       = get_bit_op_i & ~stall_cpu_o;
    assign pad_fill    = serve & short;

    always_comb begin
        src = buf_q;
        if (pad_fill) begin
            src = buf_q | ({BUF_W{PAD_BIT}} & (32'hFFFF_FFFF >> fill_q));
        end
        taken  = (n6 == 6'd0) ? 32'd0 : (src >> (6'd32 - n6));
        fill_c = fill_q;
        buf_c  = buf_q;
        if (serve) begin
            fill_c = pad_fill ? 6'd0 : (fill_q - n6);
            buf_c  = pad_fill ? 32'd0 : (buf_q << n);
        end
    end

    assign space_ok = fill_c <= 6'(FETCH_LIMIT);

    or1200_vlx_unstuff u_unstuff (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_wr),
        .resume_i      (stat_wr),
        .space_ok_i    (space_ok),
        .ack_i         (ack_i),
        .rd_dat_i      (rd_dat_i),
        .rd_req_o      (rd_req_o),
        .byte_valid_o  (byte_valid),
        .byte_o        (byte_val),
        .stuff_drop_o  (stuff_drop),
        .marker_o      (marker),
        .marker_code_o (marker_code)
    );

    always_comb begin
        bits_d      = serve ? taken : bits_q;
        buf_d       = buf_c;
        fill_d      = fill_c;
        underflow_d = underflow_q | pad_fill;
        addr_d      = addr_q;
        if (byte_valid) begin
            buf_d  = buf_c | ({byte_val, 24'h000000} >> fill_c);
            fill_d = fill_c + 6'd8;
        end
        if (rd_req_o & ack_i) begin
            addr_d = addr_q + 32'd1;
        end
        if (stat_wr) begin
            underflow_d = 1'b0;
        end
        if (start_wr) begin
            buf_d       = '0;
            fill_d      = 6'd0;
            underflow_d = 1'b0;
            addr_d      = spr_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q       <= '0;
            fill_q      <= 6'd0;
            underflow_q <= 1'b0;
            bits_q      <= 32'd0;
            addr_q      <= RESET_ADDR;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            underflow_q <= underflow_d;
            bits_q      <= bits_d;
            addr_q      <= addr_d;
        end
    end

`ifdef OR1200_VLX_READER_STATS_EN
    logic [15:0] stats_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stats_q <= 16'd0;
        end else if (start_wr) begin
            stats_q <= 16'd0;
        end else if (stuff_drop && (stats_q != 16'hFFFF)) begin
            stats_q <= stats_q + 16'd1;
        end
    end

    assign stats_val = {16'd0, stats_q};
`else
    logic unused_stuff_drop;
    assign unused_stuff_drop = stuff_drop;
    assign stats_val         = 32'd0;
`endif

    always_comb begin
        spr_dat_o = 32'd0;
        if (spr_cs) begin
            unique case (spr_addr)
                VLX_SPR_STAT:  spr_dat_o = {16'd0, marker_code, marker, underflow_q, fill_q};
                VLX_SPR_BUF:   spr_dat_o = buf_q;
                VLX_SPR_ADDR:  spr_dat_o = addr_q;
                VLX_SPR_STATS: spr_dat_o = stats_val;
            endcase
        end
    end

    assign bits_o    = bits_q;
    assign rd_addr_o = addr_q;

endmodule
